// File: rtl/h14tx_pkg.sv
// Shared types and timing constants for the HDMI 1.4 transmitter datapath.
package h14tx_pkg;

    // Period driven toward the TMDS channels.
    typedef enum logic [1:0] {
        Control      = 2'd0,
        DataPreamble = 2'd1,
        DataGuard    = 2'd2,
        Data         = 2'd3
    } period_t;

    // Data-island scheduler sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_PRE    = 3'd2,
        S_LGUARD = 3'd3,
        S_DATA   = 3'd4,
        S_TGUARD = 3'd5
    } sched_state_t;

    localparam int CtlGap      = 4;
    localparam int PreambleLen = 8;
    localparam int GuardLen    = 2;
    localparam int PacketLen   = 32;
    localparam int TailReserve = 12;

    // Number of packets that fit in one blanking interval, capped at the HDMI limit.
    function automatic int calc_npackets(input int hblank, input int max_packets);
        int fit;
        fit = (hblank - CtlGap - PreambleLen - 2 * GuardLen - TailReserve) / PacketLen;
        return (fit < max_packets) ? fit : max_packets;
    endfunction

    // Period seen on the wire while the sequencer sits in a given state.
    function automatic period_t period_of(input sched_state_t s);
        case (s)
            S_PRE:              return DataPreamble;
            S_LGUARD, S_TGUARD: return DataGuard;
            S_DATA:             return Data;
            default:            return Control;
        endcase
    endfunction

endpackage

// File: rtl/h14tx_rr_arbiter.sv
// Round-robin arbiter: the search starts at the slot after the last grant.
// The grant is combinational; the pointer moves only when advance takes a grant.
module h14tx_rr_arbiter
    import h14tx_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [NumReq-1:0] req,
    input  logic              advance,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx,
    output logic              any
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] cand;

    // First requester found scanning upward from the pointer, with wrap.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = IdxW'((int'(ptr_q) + i) % NumReq);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    // Pointer persists across lines; it moves past the winner on each taken grant.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && any) begin
            ptr_q <= (idx == IdxW'(NumReq - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/h14tx_island_sched.sv
// Data-island scheduler: per horizontal blanking it sequences control gap,
// preamble, leading guard, packets and trailing guard, and assigns packet
// slots to the requesting sources round-robin. All outputs are registered
// from the next-state decode so they line up with the state register.
module h14tx_island_sched
    import h14tx_pkg::*;
#(
    parameter  int NumReq     = 4,
    parameter  int HBlank     = 370,
    parameter  int MaxPackets = 18,
    localparam int SelW       = $clog2(NumReq)
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic              hblank_start,
    input  logic [NumReq-1:0] req,
    output logic [NumReq-1:0] grant,
    output logic [SelW-1:0]   pkt_sel,
    output logic [4:0]        pkt_idx,
    output period_t           period,
    output logic              island_active,
    output sched_state_t      dbg_state
);

    localparam int NPackets = calc_npackets(HBlank, MaxPackets);
    localparam int LeftW    = $clog2(MaxPackets + 1);

    if (NPackets < 1) begin : g_budget_check
        $error("h14tx_island_sched: blanking interval too short for one packet");
    end

    sched_state_t      state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [LeftW-1:0]  left_q, left_d;
    logic              advance;
    logic              took;
    logic [NumReq-1:0] arb_gnt;
    logic [SelW-1:0]   arb_idx;
    logic              arb_any;

    h14tx_rr_arbiter #(.NumReq(NumReq)) u_arb (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .req       (req),
        .advance   (advance),
        .gnt       (arb_gnt),
        .idx       (arb_idx),
        .any       (arb_any)
    );

    assign took      = advance && arb_any;
    assign dbg_state = state_q;

    // Next state, cycle counter and packet budget; advance marks arbitration cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        left_d  = left_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (hblank_start) state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == 5'(CtlGap - 1)) begin
                    cnt_d = '0;
                    if (|req) begin
                        state_d = S_PRE;
                        left_d  = LeftW'(NPackets);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == 5'(PreambleLen - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LGUARD;
                end
            end
            S_LGUARD: begin
                if (cnt_q == 5'(GuardLen - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    advance = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == 5'(PacketLen - 1)) begin
                    cnt_d = '0;
                    if ((|req) && (left_q != '0)) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_TGUARD;
                    end
                end
            end
            S_TGUARD: begin
                if (cnt_q == 5'(GuardLen - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (took) left_d = left_d - LeftW'(1);
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            left_q        <= '0;
            grant         <= '0;
            pkt_sel       <= '0;
            pkt_idx       <= '0;
            period        <= Control;
            island_active <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            grant         <= took ? arb_gnt : '0;
            if (took) pkt_sel <= arb_idx;
            pkt_idx       <= (state_d == S_DATA) ? cnt_d : '0;
            period        <= period_of(state_d);
            island_active <= (state_d != S_IDLE) && (state_d != S_GAP);
        end
    end

endmodule
